// File: rtl/posit_operand_pairer_pkg.sv
// Shared types and helpers for the posit operand pairer.
// Holds the pairing FSM state type and the NaR detector used on operand words.
package posit_pkg;

    localparam int POSIT_NBITS_DEF = 4;
    localparam int POSIT_MAXW      = 64;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        HAVE_A = 1'b1
    } pair_state_t;

    // Callers zero-extend the word, so NaR is exactly a lone bit at position nbits-1.
    function automatic logic is_nar(input logic [POSIT_MAXW-1:0] word, input int nbits);
        return word == (POSIT_MAXW'(1) << (nbits - 1));
    endfunction

endpackage

// File: rtl/posit_operand_pairer_fifo.sv
// Small synchronous word FIFO without fall-through: a pushed word is visible on dout
// from the following cycle. Pointers wrap naturally because DEPTH is a power of two.
module posit_word_fifo #(
    parameter int NBITS = 4,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             push,
    input  logic [NBITS-1:0] din,
    input  logic             pop,
    output logic [NBITS-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NBITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    // A push is refused while full even if a pop frees a slot in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/posit_operand_pairer.sv
// Operand front end for the posit LUT operator: buffers incoming words, forms (a,b)
// or (x,x) pairs, and presents them on a registered valid/ready operand port.
module posit_operand_pairer
    import posit_pkg::*;
#(
    parameter int NBITS = POSIT_NBITS_DEF,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_data,
    input  logic             square,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [NBITS-1:0] op_a,
    output logic [NBITS-1:0] op_b,
    output logic             op_nar,
    output logic [CNTW-1:0]  pair_cnt,
    output logic             half_pending
);

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [NBITS-1:0] w_fifo_dout;
    logic             w_slot_free;
    logic             w_pop_sq;
    logic             w_pop_a;
    logic             w_pop_b;
    logic             w_load;
    logic [NBITS-1:0] w_next_a;
    logic [NBITS-1:0] w_next_b;

    pair_state_t      r_state;
    logic [NBITS-1:0] r_a_hold;
    logic [NBITS-1:0] r_op_a;
    logic [NBITS-1:0] r_op_b;
    logic             r_op_valid;
    logic             r_op_nar;
    logic [CNTW-1:0]  r_pair_cnt;

    posit_word_fifo #(
        .NBITS (NBITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .push  (w_push),
        .din   (in_data),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;
    assign w_slot_free = !r_op_valid || op_ready;

    // Capturing an a-word never touches the output register, so it needs no free slot.
    assign w_pop_sq = (r_state == IDLE)   && !w_empty &&  square && w_slot_free;
    assign w_pop_a  = (r_state == IDLE)   && !w_empty && !square;
    assign w_pop_b  = (r_state == HAVE_A) && !w_empty && w_slot_free;
    assign w_load   = w_pop_sq || w_pop_b;
    assign w_pop    = w_load || w_pop_a;
    assign w_next_a = w_pop_b ? r_a_hold : w_fifo_dout;
    assign w_next_b = w_fifo_dout;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= IDLE;
            r_a_hold   <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
            r_op_nar   <= 1'b0;
            r_pair_cnt <= '0;
        end else begin
            if (r_op_valid && op_ready) r_pair_cnt <= r_pair_cnt + 1'b1;

            // A load may coincide with consumption of the previous pair: no bubble.
            if (w_load) begin
                r_op_a     <= w_next_a;
                r_op_b     <= w_next_b;
                r_op_nar   <= is_nar(POSIT_MAXW'(w_next_a), NBITS) ||
                              is_nar(POSIT_MAXW'(w_next_b), NBITS);
                r_op_valid <= 1'b1;
            end else if (op_ready) begin
                r_op_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_pop_a) begin
                        r_a_hold <= w_fifo_dout;
                        r_state  <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (w_pop_b) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign op_valid     = r_op_valid;
    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign op_nar       = r_op_nar;
    assign pair_cnt     = r_pair_cnt;
    assign half_pending = (r_state == HAVE_A);

endmodule

// File: tb/tb_posit_operand_pairer.sv
// Bench for posit_operand_pairer: directed scenarios plus random streams checked
// against a word-level pairing model and pair scoreboard.
module tb_posit_operand_pairer;

    localparam int NB = 4;
    localparam int DP = 4;
    localparam int CW = 4;
    localparam logic [NB-1:0] NAR = 4'h8;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] in_data = '0;
    logic          square = 1'b1;
    logic          op_valid;
    logic          op_ready = 1'b1;
    logic [NB-1:0] op_a;
    logic [NB-1:0] op_b;
    logic          op_nar;
    logic [CW-1:0] pair_cnt;
    logic          half_pending;

    int total = 0;
    int bad   = 0;

    // Reference model state: expected pairs {a,b} in issue order.
    logic [2*NB-1:0] exp_q[$];
    logic            pend_v = 1'b0;
    logic [NB-1:0]   pend_w = '0;
    logic [CW-1:0]   mcnt = '0;
    logic            hold_v = 1'b0;
    logic [NB-1:0]   ha, hb;
    logic            hn;

    posit_operand_pairer #(.NBITS(NB), .DEPTH(DP), .CNTW(CW)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .square       (square),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_nar       (op_nar),
        .pair_cnt     (pair_cnt),
        .half_pending (half_pending)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_word(input logic [NB-1:0] w, input logic sq);
        if (pend_v) begin
            exp_q.push_back({pend_w, w});
            pend_v = 1'b0;
        end else if (sq) begin
            exp_q.push_back({w, w});
        end else begin
            pend_w = w;
            pend_v = 1'b1;
        end
    endtask

    // Monitor on the falling edge, where all inputs and registered outputs are stable.
    always @(negedge CLK) begin
        logic [2*NB-1:0] e;
        if (!RSTN) begin
            exp_q.delete();
            pend_v = 1'b0;
            mcnt   = '0;
            hold_v = 1'b0;
        end else begin
            check("pair_cnt", 32'(pair_cnt), 32'(mcnt));
            if (hold_v) begin
                check("hold_valid", 32'(op_valid), 32'd1);
                check("hold_a", 32'(op_a), 32'(ha));
                check("hold_b", 32'(op_b), 32'(hb));
                check("hold_nar", 32'(op_nar), 32'(hn));
            end
            if (op_valid && op_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("pair_a", 32'(op_a), 32'(e[2*NB-1:NB]));
                    check("pair_b", 32'(op_b), 32'(e[NB-1:0]));
                    check("pair_nar", 32'(op_nar),
                          32'((e[2*NB-1:NB] == NAR) || (e[NB-1:0] == NAR)));
                end
                mcnt = mcnt + 1'b1;
            end
            hold_v = op_valid && !op_ready;
            ha = op_a;
            hb = op_b;
            hn = op_nar;
            if (in_valid && in_ready) model_word(in_data, square);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [NB-1:0] w);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 64; n++) begin
            acc = in_ready;
            cyc();
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        op_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (exp_q.size() == 0 && !op_valid) break;
            cyc();
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        RSTN = 1'b0;
        cyc();
        cyc();
        RSTN = 1'b1;
        cyc();
    endtask

    task automatic random_segment(input logic sq, input int nwords);
        int remaining;
        logic acc;
        square = sq;
        remaining = nwords;
        for (int c = 0; c < 3000 && remaining > 0; c++) begin
            in_valid = ($urandom % 3) != 0;
            in_data  = NB'($urandom);
            op_ready = ($urandom % 2) != 0;
            acc = in_valid && in_ready;
            cyc();
            if (acc) remaining--;
        end
        in_valid = 1'b0;
        check("rand_words_left", 32'(remaining), 32'd0);
        drain();
        cyc();
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset held with input activity.
        RSTN = 1'b0;
        in_valid = 1'b1;
        in_data = 4'h3;
        square = 1'b1;
        op_ready = 1'b1;
        cyc(); cyc(); cyc();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_pair_cnt", 32'(pair_cnt), 32'd0);
        check("rst_half", 32'(half_pending), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        in_valid = 1'b0;
        RSTN = 1'b1;
        cyc();
        push_word(4'h3);
        check("lat_t1_valid", 32'(op_valid), 32'd0);
        cyc();
        check("lat_t2_valid", 32'(op_valid), 32'd1);
        check("lat_t2_a", 32'(op_a), 32'h3);
        check("lat_t2_b", 32'(op_b), 32'h3);
        drain();

        // Pair mode.
        do_reset();
        square = 1'b0;
        op_ready = 1'b1;
        push_word(4'h1);
        cyc();
        check("pair_half_pending", 32'(half_pending), 32'd1);
        push_word(4'h2);
        push_word(4'h3);
        push_word(4'h4);
        drain();
        check("pair_cnt_2", 32'(pair_cnt), 32'd2);
        check("pair_last_a", 32'(op_a), 32'h3);
        check("pair_last_b", 32'(op_b), 32'h4);
        check("pair_half_clear", 32'(half_pending), 32'd0);

        // Backpressure and full FIFO.
        do_reset();
        square = 1'b1;
        op_ready = 1'b0;
        push_word(4'h5);
        push_word(4'h6);
        push_word(4'h7);
        push_word(4'h8);
        push_word(4'h9);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(op_valid), 32'd1);
        check("bp_a", 32'(op_a), 32'h5);
        in_valid = 1'b1;
        in_data = 4'hA;
        cyc(); cyc(); cyc();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_stable_b", 32'(op_b), 32'h5);
        op_ready = 1'b1;
        push_word(4'hA);
        drain();
        check("bp_cnt", 32'(pair_cnt), 32'd6);

        // NaR flag.
        square = 1'b0;
        push_word(4'h8);
        push_word(4'h2);
        drain();
        check("nar_set", 32'(op_nar), 32'd1);
        check("nar_a", 32'(op_a), 32'h8);
        push_word(4'h2);
        push_word(4'h3);
        drain();
        check("nar_clear", 32'(op_nar), 32'd0);

        // Mode switch while an a-word is pending.
        square = 1'b0;
        push_word(4'h7);
        cyc();
        check("sw_half", 32'(half_pending), 32'd1);
        square = 1'b1;
        push_word(4'h9);
        drain();
        check("sw_a", 32'(op_a), 32'h7);
        check("sw_b", 32'(op_b), 32'h9);
        push_word(4'hA);
        drain();
        check("sw_sq_a", 32'(op_a), 32'hA);
        check("sw_sq_b", 32'(op_b), 32'hA);

        // Counter wrap, then reset with a pending a-word and a non-empty FIFO.
        do_reset();
        square = 1'b1;
        op_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(NB'(i));
        drain();
        check("wrap_cnt", 32'(pair_cnt), 32'd1);
        square = 1'b0;
        op_ready = 1'b0;
        push_word(4'hB);
        push_word(4'hC);
        push_word(4'hD);
        push_word(4'hE);
        cyc(); cyc();
        check("mid_half", 32'(half_pending), 32'd1);
        check("mid_valid", 32'(op_valid), 32'd1);
        RSTN = 1'b0;
        #1;
        check("mid_rst_valid", 32'(op_valid), 32'd0);
        check("mid_rst_half", 32'(half_pending), 32'd0);
        check("mid_rst_cnt", 32'(pair_cnt), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_ab", 32'({op_a, op_b, op_nar}), 32'd0);
        cyc(); cyc();
        RSTN = 1'b1;
        cyc();
        op_ready = 1'b1;
        push_word(4'h1);
        push_word(4'h2);
        drain();
        check("fresh_a", 32'(op_a), 32'h1);
        check("fresh_b", 32'(op_b), 32'h2);
        check("fresh_cnt", 32'(pair_cnt), 32'd1);

        // Random streams with random backpressure, one mode per segment.
        for (int s = 0; s < 6; s++) begin
            if (s % 2 == 0) random_segment(1'b1, $urandom_range(20, 40));
            else            random_segment(1'b0, 2 * $urandom_range(10, 20));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
